mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// Memory stage sitting directly downstream of the execute stage. Consumes EX results
// (rd, value, address, func3 mode, read/write flags) and performs loads and stores over
// a req/ready data-memory port: store byte enables, load extract and extend.
// Registers the result towards writeback and stalls upstream while an access is in flight.
// PARAMETERS
// width        32  data/address width (byte-lane logic is fixed to 4 lanes)
// rsWidth      5   register specifier width
// PORTS
// clk            in   1        clock, rising edge
// rst            in   1        asynchronous, active-high reset
// stall          in   1        downstream hold; freezes writeback outputs
// readIn         in   1        EX op is a load
// writeIn        in   1        EX op is a store
// noMEMIn        in   1        EX op bypasses memory; valueIn forwarded as result
// valueIn        in   width    ALU result (non-mem op) or store data (store)
// addressIn      in   width    effective byte address
// addressModeIn  in   3        func3: 0 B, 1 H, 2 W, 4 BU, 5 HU
// rdIn           in   rsWidth  destination register
// memReq         out  1        memory request, held until accepted
// memWe          out  1        1 = write, 0 = read; valid with memReq
// memAddr        out  width    word-aligned address ({addressIn[width-1:2],2'b00})
// memWData       out  width    lane-replicated store data
// memByteEn      out  4        store byte enables; 4'b0000 on reads
// memRData       in   width    read data, valid when memReq && memReady
// memReady       in   1        transfer completes on a cycle with memReq && memReady
// valueOut       out  width    writeback value
// rdOut          out  rsWidth  writeback register
// regWriteOut    out  1        writeback enable
// misalignOut    out  1        one-cycle flag: misaligned or illegal access dropped
// stallOut       out  1        upstream must hold EX inputs
// BEHAVIOUR
// - Reset: state IDLE; memReq, memWe, regWriteOut, misalignOut = 0; memByteEn = 0;
//   valueOut, rdOut, memAddr, memWData = 0. Reset mid-access drops memReq at once and
//   discards the op.
// - Priority: readIn > writeIn > noMEMIn. readIn && writeIn together = illegal.
// - FSM states IDLE, REQ, DONE.
//   - IDLE, non-mem op, !stall: next edge valueOut <= valueIn, rdOut <= rdIn,
//     regWriteOut <= (rdIn != 0). Latency 1.
//   - IDLE, mem op, legal: stallOut = 1 combinationally; capture address, mode, rd
//     and data; go to REQ.
//   - REQ: memReq = 1 (only while !stall; issue is held off during stall). Address,
//     data and enables stay stable until the handshake.
//   - On memReq && memReady: latch the extended load data. If !stall, update writeback
//     (loads: regWriteOut = (rd != 0); stores: regWriteOut = 0) and return to IDLE.
//     If stall, go to DONE holding the latched result.
//   - DONE: stallOut = 1; on the first !stall cycle, write back and go to IDLE.
//   - stallOut = 1 in REQ and DONE, and in IDLE when a mem op is present.
// - Misaligned H/HU with addr[0]; W with addr[1:0] != 0; func3 outside the table;
//   or read && write:
//   - no memory access is issued.
//   - misalignOut = 1 for one cycle; regWriteOut = 0.
//   - The op is consumed in 1 cycle.
// - Stores:
//   - SB: en = 4'b0001 << addr[1:0], data = {4{d[7:0]}}.
//   - SH: en = 4'b0011 << addr[1:0], data = {2{d[15:0]}}.
//   - SW: en = 4'b1111.
// - Loads select the byte/half by addr[1:0]. B and H sign-extend; BU and HU
//   zero-extend; W passes through unchanged.
// - stall with no pending access: all writeback outputs hold; regWriteOut is held,
//   not re-asserted.
// TESTING
// - ALU op rd=5 value=0x1234, noMEM -> next cycle valueOut=0x1234, rdOut=5, regWriteOut=1, memReq=0.
// - LB addr=0x103, memRData=0x80FF_0000, memReady after 2 cycles -> valueOut=0xFFFF_FF80, stallOut high 3 cycles.
// - SH addr=0x102, data=0xABCD -> memByteEn=4'b1100, memWData=0xABCD_ABCD, memAddr=0x100, regWriteOut=0.
// - LW addr=0x101 -> misalignOut=1 for one cycle, memReq never asserted, regWriteOut=0.
// - LHU completes while stall=1 for 3 cycles -> result held in DONE; valueOut updates on the first !stall edge.
// - rst asserted while memReq=1 -> memReq=0 immediately, state IDLE, no writeback.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage between EX and WB; issues loads/stores on a req/ready
//   data port, builds store byte enables and lanes, and extracts/extends load data.
// Latency: non-mem ops 1 cycle; legal mem ops 1 cycle plus memory wait plus any
//   downstream stall; illegal/misaligned accesses are dropped in 1 cycle.
// Backpressure: stallOut holds EX while an access is outstanding; stall freezes the
//   writeback outputs and defers request issue, but an issued request stays up
//   until memReady accepts it.
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   stall                         downstream hold
//   readIn/writeIn/noMEMIn        EX op kind (read > write > noMEM)
//   valueIn/addressIn             ALU result or store data / byte address
//   addressModeIn, rdIn           func3 access mode / destination register
//   memReq/memWe/memAddr/...      data-memory request side
//   memRData/memReady             data-memory response side
//   valueOut/rdOut/regWriteOut    writeback result
//   misalignOut                   one-cycle flag for a dropped access
//   stallOut                      upstream hold
module mem_stage #(
  parameter int width   = 32,
  parameter int rsWidth = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               readIn,
  input  logic               writeIn,
  input  logic               noMEMIn,
  input  logic [width-1:0]   valueIn,
  input  logic [width-1:0]   addressIn,
  input  logic [2:0]         addressModeIn,
  input  logic [rsWidth-1:0] rdIn,
  output logic               memReq,
  output logic               memWe,
  output logic [width-1:0]   memAddr,
  output logic [width-1:0]   memWData,
  output logic [3:0]         memByteEn,
  input  logic [width-1:0]   memRData,
  input  logic               memReady,
  output logic [width-1:0]   valueOut,
  output logic [rsWidth-1:0] rdOut,
  output logic               regWriteOut,
  output logic               misalignOut,
  output logic               stallOut
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Access context captured when the op leaves IDLE; EX inputs are not
  // relied upon after that point.
  typedef struct packed {
    logic               isLoad;
    logic [2:0]         mode;
    logic [1:0]         offset;
    logic [rsWidth-1:0] rd;
  } memOp_t;

  logic [1:0]       state;
  memOp_t           op;
  logic             issued;   // memReq has been raised and not yet accepted
  logic [width-1:0] result;   // load data held while parked in DONE

  logic             memOpIn;
  logic             modeOk;
  logic             alignOk;
  logic             illegal;
  logic             startMem;
  logic             xfer;
  logic             retire;
  logic [3:0]       stEn;
  logic [width-1:0] stData;
  logic [7:0]       ldByte;
  logic [15:0]      ldHalf;
  logic [width-1:0] ldData;
  logic [width-1:0] wbValue;

  // Mode legality, alignment and store lane construction from the EX inputs.
  always_comb begin
    modeOk  = 1'b0;
    alignOk = 1'b1;
    stEn    = 4'b0000;
    case (addressModeIn)
      3'd0, 3'd4: begin
        modeOk = 1'b1;
        stEn   = 4'b0001 << addressIn[1:0];
      end
      3'd1, 3'd5: begin
        modeOk  = 1'b1;
        alignOk = ~addressIn[0];
        stEn    = 4'b0011 << addressIn[1:0];
      end
      3'd2: begin
        modeOk  = 1'b1;
        alignOk = (addressIn[1:0] == 2'b00);
        stEn    = 4'b1111;
      end
      default: ;
    endcase

    case (addressModeIn[1:0])
      2'd0:    stData = {(width/8){valueIn[7:0]}};
      2'd1:    stData = {(width/16){valueIn[15:0]}};
      default: stData = valueIn;
    endcase
  end

  assign memOpIn  = readIn | writeIn;
  assign illegal  = memOpIn && ((readIn && writeIn) || !modeOk || !alignOk);
  assign startMem = (state == IDLE) && memOpIn && !illegal;

  // A new request is not raised during stall, but once raised it is held.
  assign memReq = (state == REQ) && (issued || !stall);
  assign xfer   = memReq && memReady;

  // The op retires on the edge where its result moves to writeback; stallOut
  // drops in that cycle so upstream advances exactly once per op.
  assign retire   = ((state == REQ) && xfer && !stall) || ((state == DONE) && !stall);
  assign stallOut = startMem
                 || ((state == REQ) && !(xfer && !stall))
                 || ((state == DONE) && stall);

  // Load lane select and extension, driven from the captured offset/mode.
  assign ldByte = memRData[{op.offset, 3'b000} +: 8];
  assign ldHalf = memRData[{op.offset[1], 4'b0000} +: 16];

  always_comb begin
    case (op.mode)
      3'd0:    ldData = {{(width-8){ldByte[7]}}, ldByte};
      3'd1:    ldData = {{(width-16){ldHalf[15]}}, ldHalf};
      3'd4:    ldData = {{(width-8){1'b0}}, ldByte};
      3'd5:    ldData = {{(width-16){1'b0}}, ldHalf};
      default: ldData = memRData;
    endcase
  end

  assign wbValue = (state == DONE) ? result : ldData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op          <= '0;
      issued      <= 1'b0;
      result      <= '0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWData    <= '0;
      memByteEn   <= 4'b0000;
      valueOut    <= '0;
      rdOut       <= '0;
      regWriteOut <= 1'b0;
      misalignOut <= 1'b0;
    end else begin
      misalignOut <= 1'b0;

      case (state)
        IDLE: begin
          if (startMem) begin
            op.isLoad <= readIn;
            op.mode   <= addressModeIn;
            op.offset <= addressIn[1:0];
            op.rd     <= rdIn;
            memAddr   <= {addressIn[width-1:2], 2'b00};
            memWe     <= writeIn;
            memByteEn <= readIn ? 4'b0000 : stEn;
            memWData  <= stData;
            issued    <= 1'b0;
            state     <= REQ;
            if (!stall) regWriteOut <= 1'b0;
          end else if (!stall) begin
            if (illegal) begin
              misalignOut <= 1'b1;
              regWriteOut <= 1'b0;
            end else if (noMEMIn) begin
              valueOut    <= valueIn;
              rdOut       <= rdIn;
              regWriteOut <= |rdIn;
            end else begin
              regWriteOut <= 1'b0;
            end
          end
        end

        REQ: begin
          if (xfer) begin
            issued <= 1'b0;
            result <= ldData;
            state  <= stall ? DONE : IDLE;
          end else begin
            issued <= memReq;
            if (!stall) regWriteOut <= 1'b0;
          end
        end

        DONE: begin
          if (!stall) state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      if (retire) begin
        if (op.isLoad) begin
          valueOut    <= wbValue;
          rdOut       <= op.rd;
          regWriteOut <= |op.rd;
        end else begin
          regWriteOut <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
//   transaction-level reference (upstream holds while stall || stallOut).
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        readIn;
  logic        writeIn;
  logic        noMEMIn;
  logic [31:0] valueIn;
  logic [31:0] addressIn;
  logic [2:0]  addressModeIn;
  logic [4:0]  rdIn;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memByteEn;
  logic [31:0] memRData;
  logic        memReady;
  logic [31:0] valueOut;
  logic [4:0]  rdOut;
  logic        regWriteOut;
  logic        misalignOut;
  logic        stallOut;

  int vectors;
  int miscompares;

  logic [31:0] bmem [16];
  logic [31:0] eVal;
  logic [4:0]  eRd;
  logic        eRW;
  logic        eMis;

  mem_stage #(.width(32), .rsWidth(5)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .readIn(readIn), .writeIn(writeIn), .noMEMIn(noMEMIn),
    .valueIn(valueIn), .addressIn(addressIn), .addressModeIn(addressModeIn), .rdIn(rdIn),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memByteEn(memByteEn), .memRData(memRData), .memReady(memReady),
    .valueOut(valueOut), .rdOut(rdOut), .regWriteOut(regWriteOut),
    .misalignOut(misalignOut), .stallOut(stallOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] mode);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (mode)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // Presents one op, holding it until consumed; masks give per-cycle stall/ready.
  task automatic run_op(input logic rd_, input logic wr_, input logic nm_,
                        input logic [31:0] val, input logic [31:0] addr,
                        input logic [2:0] mode, input logic [4:0] rd,
                        input logic [31:0] sMask, input logic [31:0] rMask,
                        output int nStall);
    logic        isMem, legalMode, aligned, illegal, legalMem, isLoad;
    logic        hs, pending, done, s, r, eReq, eStall, hsNow;
    logic [31:0] eEn, eData, ldVal, wmask;
    int          idx, cyc;

    isMem     = rd_ | wr_;
    legalMode = (mode == 3'd0) || (mode == 3'd1) || (mode == 3'd2) || (mode == 3'd4) || (mode == 3'd5);
    aligned   = ((mode == 3'd1) || (mode == 3'd5)) ? (addr[0] == 1'b0) :
                (mode == 3'd2) ? (addr[1:0] == 2'b00) : 1'b1;
    illegal   = isMem && ((rd_ && wr_) || !legalMode || !aligned);
    legalMem  = isMem && !illegal;
    isLoad    = rd_;
    idx       = int'(addr[5:2]);

    if (mode == 3'd0) begin
      eEn   = 32'd1 << addr[1:0];
      eData = (val & 32'hFF) * 32'h0101_0101;
    end else if (mode == 3'd1) begin
      eEn   = 32'd3 << addr[1:0];
      eData = (val & 32'hFFFF) * 32'h0001_0001;
    end else begin
      eEn   = 32'hF;
      eData = val;
    end
    if (isLoad) eEn = 32'd0;

    ldVal = 32'd0; hs = 1'b0; pending = 1'b0; done = 1'b0; cyc = 0; nStall = 0;
    while (!done && cyc < 48) begin
      @(negedge clk);
      s = (cyc < 32) ? sMask[cyc] : 1'b0;
      r = (cyc < 32) ? rMask[cyc] : 1'b1;
      readIn = rd_; writeIn = wr_; noMEMIn = nm_;
      valueIn = val; addressIn = addr; addressModeIn = mode; rdIn = rd;
      stall = s; memReady = r;
      memRData = isLoad ? bmem[idx] : $urandom;
      #1;
      eReq   = legalMem && (cyc > 0) && !hs && (pending || !s);
      hsNow  = eReq && r;
      eStall = legalMem && !((hs || hsNow) && !s);
      chk("memReq", 32'(memReq), 32'(eReq));
      chk("stallOut", 32'(stallOut), 32'(eStall));
      if (eReq) begin
        chk("memAddr", memAddr, addr & 32'hFFFF_FFFC);
        chk("memWe", 32'(memWe), 32'(wr_));
        chk("memByteEn", 32'(memByteEn), eEn);
        if (!isLoad) chk("memWData", memWData, eData);
      end
      if (stallOut) nStall++;
      if (hsNow) begin
        if (isLoad) begin
          ldVal = load_val(bmem[idx], addr, mode);
        end else begin
          wmask = 32'd0;
          for (int i = 0; i < 4; i++) if (eEn[i]) wmask[8*i +: 8] = 8'hFF;
          bmem[idx] = (bmem[idx] & ~wmask) | (eData & wmask);
        end
      end
      pending = hsNow ? 1'b0 : (pending || eReq);
      hs      = hs || hsNow;
      done    = !s && !eStall;

      @(posedge clk);
      #1;
      if (!s) begin
        eMis = done && illegal;
        if (done && illegal) begin
          eRW = 1'b0;
        end else if (done && legalMem && isLoad) begin
          eVal = ldVal; eRd = rd; eRW = (rd != 5'd0);
        end else if (done && !isMem && nm_) begin
          eVal = val; eRd = rd; eRW = (rd != 5'd0);
        end else begin
          eRW = 1'b0;
        end
      end else begin
        eMis = 1'b0;
      end
      chk("valueOut", valueOut, eVal);
      chk("rdOut", 32'(rdOut), 32'(eRd));
      chk("regWriteOut", 32'(regWriteOut), 32'(eRW));
      chk("misalignOut", 32'(misalignOut), 32'(eMis));
      cyc++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL op_timeout observed=not_consumed expected=consumed_within_48_cycles");
    end
  endtask

  logic [2:0] legalModes [5];
  logic [2:0] badModes   [3];

  initial begin
    int          sc, k;
    logic [31:0] a, v;
    logic [2:0]  m;
    logic [4:0]  rr;

    vectors = 0; miscompares = 0;
    legalModes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    badModes   = '{3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 16; i++) bmem[i] = $urandom;

    rst = 1'b1; stall = 1'b0; readIn = 1'b0; writeIn = 1'b0; noMEMIn = 1'b0;
    valueIn = 32'd0; addressIn = 32'd0; addressModeIn = 3'd0; rdIn = 5'd0;
    memRData = 32'd0; memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memWe", 32'(memWe), 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memWData", memWData, 32'd0);
    chk("rst_memByteEn", 32'(memByteEn), 32'd0);
    chk("rst_valueOut", valueOut, 32'd0);
    chk("rst_rdOut", 32'(rdOut), 32'd0);
    chk("rst_regWriteOut", 32'(regWriteOut), 32'd0);
    chk("rst_misalignOut", 32'(misalignOut), 32'd0);
    chk("rst_stallOut", 32'(stallOut), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    eVal = 32'd0; eRd = 5'd0; eRW = 1'b0; eMis = 1'b0;

    // ALU pass-through
    run_op(1'b0, 1'b0, 1'b1, 32'h1234, 32'd0, 3'd0, 5'd5, 32'd0, 32'd0, sc);
    chk("alu_value", valueOut, 32'h1234);
    chk("alu_regWrite", 32'(regWriteOut), 32'd1);

    // LB from the top byte, memory ready in the third request cycle
    bmem[0] = 32'h80FF_0000;
    run_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h103, 3'd0, 5'd7, 32'd0, 32'b1000, sc);
    chk("lb_value", valueOut, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(sc), 32'd3);

    // SH to the upper half
    run_op(1'b0, 1'b1, 1'b0, 32'h0000_ABCD, 32'h102, 3'd1, 5'd3, 32'd0, 32'b10, sc);
    chk("sh_regWrite", 32'(regWriteOut), 32'd0);

    // Misaligned LW is dropped
    run_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h101, 3'd2, 5'd4, 32'd0, 32'hFFFF_FFFF, sc);
    chk("lw_misalign", 32'(misalignOut), 32'd1);

    // LHU accepted under stall, parked, then written back on release
    bmem[1] = 32'h89AB_1234;
    run_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h106, 3'd5, 5'd9, 32'b11100, 32'b00100, sc);
    chk("lhu_value", valueOut, 32'h0000_89AB);

    // Randomized ops
    for (int n = 0; n < 150; n++) begin
      k  = $urandom_range(0, 99);
      a  = 32'h100 + $urandom_range(0, 63);
      v  = $urandom;
      rr = 5'($urandom_range(0, 31));
      m  = legalModes[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) m = badModes[$urandom_range(0, 2)];
      if (k < 30)
        run_op(1'b0, 1'b0, 1'b1, v, a, m, rr, $urandom & $urandom, $urandom | $urandom, sc);
      else if (k < 60)
        run_op(1'b1, 1'b0, 1'b0, v, a, m, rr, $urandom & $urandom, $urandom | $urandom, sc);
      else if (k < 85) begin
        if (m == 3'd4 || m == 3'd5) m = 3'($urandom_range(0, 2));
        run_op(1'b0, 1'b1, 1'b0, v, a, m, rr, $urandom & $urandom, $urandom | $urandom, sc);
      end else if (k < 90)
        run_op(1'b1, 1'b1, 1'b0, v, a, 3'd2, rr, $urandom & $urandom, $urandom | $urandom, sc);
      else
        run_op(1'b0, 1'b0, 1'b0, v, a, m, rr, $urandom & $urandom, $urandom | $urandom, sc);
    end

    // Reset while a request is outstanding
    @(negedge clk);
    readIn = 1'b1; writeIn = 1'b0; noMEMIn = 1'b0;
    addressIn = 32'h108; addressModeIn = 3'd2; rdIn = 5'd6;
    stall = 1'b0; memReady = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_req_up", 32'(memReq), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_memReq", 32'(memReq), 32'd0);
    chk("rst_mid_regWrite", 32'(regWriteOut), 32'd0);
    chk("rst_mid_value", valueOut, 32'd0);
    readIn = 1'b0;
    #1;
    chk("rst_mid_stallOut", 32'(stallOut), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    eVal = 32'd0; eRd = 5'd0; eRW = 1'b0; eMis = 1'b0;

    run_op(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 32'd0, 3'd0, 5'd12, 32'd0, 32'd0, sc);
    chk("post_rst_value", valueOut, 32'hCAFE_F00D);
    run_op(1'b1, 1'b0, 1'b0, 32'd0, 32'h10C, 3'd2, 5'd13, 32'd0, 32'b10, sc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
